// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline M stage: write-back select, funct3 access modes,
// LSU state and the alignment check.
package pipe_pkg;

  typedef enum logic [1:0] {
    WbAlu  = 2'b00,
    WbLoad = 2'b01,
    WbPc4  = 2'b10,
    WbRsvd = 2'b11
  } wb_sel_e;

  localparam logic [2:0] ModeB  = 3'b000;
  localparam logic [2:0] ModeH  = 3'b001;
  localparam logic [2:0] ModeW  = 3'b010;
  localparam logic [2:0] ModeBu = 3'b100;
  localparam logic [2:0] ModeHu = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StWaitR = 2'b10
  } lsu_state_e;

  // Size is carried by mode[1:0]; the sign bit never affects alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the M-stage LSU (master) and the memory system (slave).
interface mem_stage_lsu_if #(
    parameter int unsigned ADDR_W = 30
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_bmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_bmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication and byte mask, load lane
// extraction with sign/zero extension.
module lsu_align
  import pipe_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_mode_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  bmask_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    wdata_o = st_data_i;
    bmask_o = 4'b1111;
    unique case (st_size_i)
      2'b00: begin
        wdata_o = {4{st_data_i[7:0]}};
        bmask_o = 4'b0001 << st_off_i;
      end
      2'b01: begin
        wdata_o = {2{st_data_i[15:0]}};
        bmask_o = 4'b0011 << st_off_i;
      end
      default: begin
        wdata_o = st_data_i;
        bmask_o = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = shifted;
    unique case (ld_mode_i)
      ModeB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      ModeH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      ModeBu:  ld_data_o = {24'h000000, shifted[7:0]};
      ModeHu:  ld_data_o = {16'h0000, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: bus request FSM, pipeline stall generation and the M->W
// register feeding the register-file write port and forwarding.
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_wr_enM,
  input  logic [1:0]          wb_selM,
  input  logic                mem_wr_enM,
  input  logic [2:0]          data_modeM,
  input  logic [31:0]         alu_dataM,
  input  logic [31:0]         FW_bM,
  input  logic [31:0]         pc4M,
  input  logic [4:0]          rd_addrM,
  mem_stage_lsu_if.master     bus,
  output logic                stall_mem,
  output logic                rd_wr_enW,
  output logic [4:0]          rd_addrW,
  output logic [31:0]         wb_dataW,
  output logic                misalign_errW
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  mode_q, mode_d;

  logic        mem_op, misalign, aligned_op;
  logic        req, retire;
  logic [31:0] ld_data, wb_data_d;

  logic        rd_wr_en_w_q, misalign_w_q;
  logic [4:0]  rd_addr_w_q;
  logic [31:0] wb_data_w_q;

  lsu_align u_align (
    .st_size_i  (data_modeM[1:0]),
    .st_off_i   (alu_dataM[1:0]),
    .st_data_i  (FW_bM),
    .ld_mode_i  (mode_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (bus.mem_rdata),
    .wdata_o    (bus.mem_wdata),
    .bmask_o    (bus.mem_bmask),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    mem_op     = mem_wr_enM | (wb_selM == WbLoad);
    misalign   = mem_op & is_misaligned(data_modeM[1:0], alu_dataM[1:0]);
    aligned_op = mem_op & ~misalign;

    state_d = state_q;
    off_d   = off_q;
    mode_d  = mode_q;
    req     = 1'b0;
    retire  = 1'b1;

    unique case (state_q)
      StIdle: begin
        req = aligned_op;
        if (aligned_op) begin
          retire = 1'b0;
          if (bus.mem_gnt) begin
            off_d  = alu_dataM[1:0];
            mode_d = data_modeM;
            if (mem_wr_enM) retire = 1'b1;
            else            state_d = StWaitR;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        req    = 1'b1;
        retire = 1'b0;
        if (bus.mem_gnt) begin
          off_d  = alu_dataM[1:0];
          mode_d = data_modeM;
          if (mem_wr_enM) begin
            retire  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        retire = 1'b0;
        if (bus.mem_rvalid) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request and stall are forced low while reset is held, independent of the M inputs.
  assign bus.mem_req  = req & rst_n;
  assign bus.mem_we   = mem_wr_enM;
  assign bus.mem_addr = alu_dataM[ADDR_W+1:2];
  assign stall_mem    = aligned_op & ~retire & rst_n;

  always_comb begin
    unique case (wb_selM)
      WbLoad:  wb_data_d = ld_data;
      WbPc4:   wb_data_d = pc4M;
      default: wb_data_d = alu_dataM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wr_en_w_q <= 1'b0;
      rd_addr_w_q  <= 5'd0;
      wb_data_w_q  <= 32'd0;
      misalign_w_q <= 1'b0;
    end else if (retire) begin
      rd_wr_en_w_q <= rd_wr_enM & ~misalign;
      rd_addr_w_q  <= rd_addrM;
      wb_data_w_q  <= wb_data_d;
      misalign_w_q <= misalign;
    end else begin
      rd_wr_en_w_q <= 1'b0;
      misalign_w_q <= 1'b0;
    end
  end

  assign rd_wr_enW     = rd_wr_en_w_q;
  assign rd_addrW      = rd_addr_w_q;
  assign wb_dataW      = wb_data_w_q;
  assign misalign_errW = misalign_w_q;

endmodule
